irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
- Interrupt controller directly upstream of the 65c02 core; drives the core's irqb and nmib inputs.
- Collects 8 asynchronous maskable sources and 1 NMI source, synchronises them to phi2, and latches edge/level events.
- Exposes four byte registers on the CPU data bus.
- Generates a properly spaced, edge-detectable NMI low pulse.

Parameters:
NMI_WIDTH, 4, phi2 cycles nmib is held low per NMI (>=1)
NMI_GAP, 2, minimum phi2 cycles nmib stays high between back-to-back NMI pulses (>=1)

Ports:
phi2  input  1  system clock; all state changes on rising edge
rst  input  1  asynchronous, active-high reset
irq_src  input  8  asynchronous interrupt sources, active high
nmi_src  input  1  asynchronous NMI source; rising edge requests an NMI
cs  input  1  register window select, from address decode
rwb  input  1  1 = read, 0 = write (core convention)
addr  input  2  register index
d_in  input  8  write data from core
d_out  output  8  read data to core data-bus mux
irqb  output  1  active-low IRQ to core, registered
nmib  output  1  active-low NMI to core, registered

Behaviour:
- Reset: irqb=1, nmib=1. STATUS, ENABLE, MODE, sync flops, edge history and NMI counter all 0. NMI FSM in IDLE. d_out=0.
- Synchronisers: 2 flops per source (s1, s2). Edge history flop prev <= s2.
- Each edge, pending[i] is updated as follows:
  - MODE[i]=0 (level): pending[i] <= s2[i]. W1C is ignored.
  - MODE[i]=1 (rising edge): set when s2 & ~prev. Cleared by a STATUS write with d_in[i]=1. Set wins over clear in the same cycle.
  - ID write with d_in[i]=1 sets pending[i] in edge mode (software trigger). It is ignored in level mode.
- Source held high through reset release in edge mode produces one pending event (sync starts at 0).
- Latency: src rises before edge 1 -> s1 at edge 1, s2 at edge 2, pending at edge 3, irqb=0 after edge 4. Deassert path has the same latency (level mode).
- irqb <= ~|(pending & ENABLE), registered.
- ENABLE=0 masks irqb but does not clear pending.
- MODE change edge->level: pending follows s2 from the next edge.
- Register map: writes occur when cs & ~rwb at the edge. Reads are combinational: d_out = selected register when cs & rwb, else 0.
  - 0 STATUS: R = pending; W = write-1-to-clear (edge-mode bits only).
  - 1 ENABLE: RW.
  - 2 MODE: RW; 1 = edge, 0 = level.
  - 3 ID: R = {active, 4'b0, idx[2:0]}.
    - active = |(pending & ENABLE).
    - idx = lowest set index of pending & ENABLE, else 0.
    - W = software set (see above).
- NMI FSM: rising edge detected on synchronised nmi_src sets nmi_req (same 3-edge latency as IRQ).
  - IDLE: nmi_req -> LOW. nmib<=0, cnt<=NMI_WIDTH-1, nmi_req cleared.
  - LOW: cnt>0 -> decrement. cnt==0 -> GAP, nmib<=1, cnt<=NMI_GAP-1.
  - GAP: cnt>0 -> decrement. cnt==0 -> IDLE.
  - An edge in LOW or GAP sets nmi_req. The request is served on return to IDLE, and multiple edges merge into one.
  - nmib low exactly NMI_WIDTH cycles. Consecutive pulses are separated by >= NMI_GAP+1 high cycles (GAP cycles plus the IDLE cycle).
- Reset mid-pulse: nmib returns to 1 immediately (async), and the request is discarded.

Test Plan:
- Reset then idle: irqb=1, nmib=1, and reads of all four addresses = 0x00.
- ENABLE=0x01, MODE=0x00; irq_src[0] high -> irqb=0 after 4th edge, ID reads 0x80. Drop src -> irqb=1 four edges later.
- MODE=0xFF, ENABLE=0x0C; 1-cycle pulse on src[3] and src[2] -> STATUS=0x0C, ID=0x82. Write STATUS 0x04 -> STATUS=0x08, ID=0x83. Write 0x08 -> irqb=1 next+1 edge.
- Edge mode bit 5: write STATUS 0x20 in the same cycle a new edge reaches detection -> pending[5] stays 1.
- nmi_src rise -> nmib low for exactly 4 cycles. Second rise during LOW -> second pulse starts after 3 high cycles. Three rises during one pulse -> only one extra pulse.
- Assert rst during an NMI pulse and with pending IRQ -> nmib=1, irqb=1, STATUS=0 immediately. Edge-mode source held high across release -> STATUS bit set 3 edges after release.

Source files
------------

// File: rtl/irq_ctrl.sv
// irq_ctrl: interrupt controller in front of the 65c02 core.
// Synchronises 8 maskable sources and one NMI source to phi2, latches
// level/edge events into STATUS, exposes STATUS/ENABLE/MODE/ID on the CPU bus,
// and produces an NMI pulse of fixed width with guaranteed inter-pulse spacing.
module irq_ctrl #(
    parameter int NMI_WIDTH = 4,
    parameter int NMI_GAP   = 2
) (
    input  logic       phi2,
    input  logic       rst,
    input  logic [7:0] irq_src,
    input  logic       nmi_src,
    input  logic       cs,
    input  logic       rwb,
    input  logic [1:0] addr,
    input  logic [7:0] d_in,
    output logic [7:0] d_out,
    output logic       irqb,
    output logic       nmib
);

    // Counter is sized for the longer of the two phases; the +1 keeps it at
    // least 2 bits wide so the decrement constant below is always well formed.
    localparam int NMI_MAX = (NMI_WIDTH > NMI_GAP) ? NMI_WIDTH : NMI_GAP;
    localparam int CW      = $clog2(NMI_MAX + 1) + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOW  = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam logic [1:0] A_STATUS = 2'd0;
    localparam logic [1:0] A_ENABLE = 2'd1;
    localparam logic [1:0] A_MODE   = 2'd2;
    localparam logic [1:0] A_ID     = 2'd3;

    logic [7:0]    irq_s1_r;
    logic [7:0]    irq_s2_r;
    logic [7:0]    irq_prev_r;
    logic [7:0]    pending_r;
    logic [7:0]    enable_r;
    logic [7:0]    mode_r;
    logic          irqb_r;

    logic          nmi_s1_r;
    logic          nmi_s2_r;
    logic          nmi_prev_r;
    logic          nmi_req_r;
    logic [1:0]    nmi_state_r;
    logic [CW-1:0] nmi_cnt_r;
    logic          nmib_r;

    logic          wr_s;
    logic          rd_s;
    logic [7:0]    status_clr_s;
    logic [7:0]    sw_set_s;
    logic [7:0]    irq_rise_s;
    logic [7:0]    pending_nxt_s;
    logic [7:0]    masked_s;
    logic          active_s;
    logic [2:0]    idx_s;
    logic          nmi_rise_s;
    logic          nmi_take_s;

    assign wr_s         = cs & ~rwb;
    assign rd_s         = cs & rwb;
    assign status_clr_s = (wr_s && (addr == A_STATUS)) ? d_in : 8'h00;
    assign sw_set_s     = (wr_s && (addr == A_ID))     ? d_in : 8'h00;
    assign irq_rise_s   = irq_s2_r & ~irq_prev_r;

    // Edge-mode bits: set (hardware edge or software trigger) beats W1C.
    // Level-mode bits simply mirror the synchronised source.
    assign pending_nxt_s = (mode_r & (irq_rise_s | sw_set_s | (pending_r & ~status_clr_s)))
                         | (~mode_r & irq_s2_r);

    assign masked_s   = pending_r & enable_r;
    assign active_s   = |masked_s;
    assign nmi_rise_s = nmi_s2_r & ~nmi_prev_r;
    assign nmi_take_s = (nmi_state_r == ST_IDLE) & nmi_req_r;

    assign irqb = irqb_r;
    assign nmib = nmib_r;

    // Lowest-numbered enabled pending source; scanning downwards lets the lowest win.
    always_comb begin
        idx_s = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (masked_s[i]) begin
                idx_s = 3'(i);
            end else begin
                idx_s = idx_s;
            end
        end
    end

    // Combinational register read mux; bus is driven to zero when not selected.
    always_comb begin
        d_out = 8'h00;
        if (rd_s) begin
            case (addr)
                A_STATUS: d_out = pending_r;
                A_ENABLE: d_out = enable_r;
                A_MODE:   d_out = mode_r;
                A_ID:     d_out = {active_s, 4'b0000, idx_s};
                default:  d_out = 8'h00;
            endcase
        end else begin
            d_out = 8'h00;
        end
    end

    // Two-flop synchronisers and edge history for the maskable sources.
    always_ff @(posedge phi2 or posedge rst) begin
        if (rst) begin
            irq_s1_r   <= 8'h00;
            irq_s2_r   <= 8'h00;
            irq_prev_r <= 8'h00;
        end else begin
            irq_s1_r   <= irq_src;
            irq_s2_r   <= irq_s1_r;
            irq_prev_r <= irq_s2_r;
        end
    end

    // ENABLE and MODE software registers.
    always_ff @(posedge phi2 or posedge rst) begin
        if (rst) begin
            enable_r <= 8'h00;
            mode_r   <= 8'h00;
        end else begin
            if (wr_s && (addr == A_ENABLE)) begin
                enable_r <= d_in;
            end
            if (wr_s && (addr == A_MODE)) begin
                mode_r <= d_in;
            end
        end
    end

    // Pending event latch (STATUS).
    always_ff @(posedge phi2 or posedge rst) begin
        if (rst) begin
            pending_r <= 8'h00;
        end else begin
            pending_r <= pending_nxt_s;
        end
    end

    // Registered active-low IRQ to the core.
    always_ff @(posedge phi2 or posedge rst) begin
        if (rst) begin
            irqb_r <= 1'b1;
        end else begin
            irqb_r <= ~active_s;
        end
    end

    // NMI synchroniser, edge history and request latch; a new edge wins over consumption.
    always_ff @(posedge phi2 or posedge rst) begin
        if (rst) begin
            nmi_s1_r   <= 1'b0;
            nmi_s2_r   <= 1'b0;
            nmi_prev_r <= 1'b0;
            nmi_req_r  <= 1'b0;
        end else begin
            nmi_s1_r   <= nmi_src;
            nmi_s2_r   <= nmi_s1_r;
            nmi_prev_r <= nmi_s2_r;
            nmi_req_r  <= nmi_rise_s | (nmi_req_r & ~nmi_take_s);
        end
    end

    // NMI pulse shaper: LOW for NMI_WIDTH cycles, then at least NMI_GAP+1 high cycles.
    always_ff @(posedge phi2 or posedge rst) begin
        if (rst) begin
            nmi_state_r <= ST_IDLE;
            nmi_cnt_r   <= {CW{1'b0}};
            nmib_r      <= 1'b1;
        end else begin
            case (nmi_state_r)
                ST_IDLE: begin
                    if (nmi_req_r) begin
                        nmi_state_r <= ST_LOW;
                        nmi_cnt_r   <= CW'(NMI_WIDTH - 1);
                        nmib_r      <= 1'b0;
                    end
                end
                ST_LOW: begin
                    if (nmi_cnt_r != {CW{1'b0}}) begin
                        nmi_cnt_r <= nmi_cnt_r - {{(CW-1){1'b0}}, 1'b1};
                    end else begin
                        nmi_state_r <= ST_GAP;
                        nmi_cnt_r   <= CW'(NMI_GAP - 1);
                        nmib_r      <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (nmi_cnt_r != {CW{1'b0}}) begin
                        nmi_cnt_r <= nmi_cnt_r - {{(CW-1){1'b0}}, 1'b1};
                    end else begin
                        nmi_state_r <= ST_IDLE;
                    end
                end
                default: begin
                    nmi_state_r <= ST_IDLE;
                    nmi_cnt_r   <= {CW{1'b0}};
                    nmib_r      <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed testbench for irq_ctrl with hand-computed expected values.
module tb_irq_ctrl;

    logic       phi2;
    logic       rst;
    logic [7:0] irq_src;
    logic       nmi_src;
    logic       cs;
    logic       rwb;
    logic [1:0] addr;
    logic [7:0] d_in;
    logic [7:0] d_out;
    logic       irqb;
    logic       nmib;

    int n_checks = 0;
    int n_errors = 0;

    irq_ctrl #(.NMI_WIDTH(4), .NMI_GAP(2)) dut (
        .phi2    (phi2),
        .rst     (rst),
        .irq_src (irq_src),
        .nmi_src (nmi_src),
        .cs      (cs),
        .rwb     (rwb),
        .addr    (addr),
        .d_in    (d_in),
        .d_out   (d_out),
        .irqb    (irqb),
        .nmib    (nmib)
    );

    // 20-unit clock period
    initial begin
        phi2 = 1'b0;
        forever #10 phi2 = ~phi2;
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    // advance past the next rising edge and settle
    task automatic tick();
        @(posedge phi2);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        cs   = 1'b1;
        rwb  = 1'b0;
        addr = a;
        d_in = d;
        tick();
        cs   = 1'b0;
        rwb  = 1'b1;
        d_in = 8'h00;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [7:0] exp);
        cs   = 1'b1;
        rwb  = 1'b1;
        addr = a;
        #1;
        chk(tag, d_out, exp);
        cs   = 1'b0;
    endtask

    // Step i drives nmi_src=src_pat[i], crosses one edge, then compares nmib to exp_pat[i].
    task automatic nmi_run(input string tag, input logic [31:0] src_pat, input logic [31:0] exp_pat);
        for (int i = 0; i < 32; i++) begin
            nmi_src = src_pat[i];
            tick();
            chk($sformatf("%s[%0d]", tag, i), {7'd0, nmib}, {7'd0, exp_pat[i]});
        end
        nmi_src = 1'b0;
        repeat (10) tick();
    endtask

    initial begin
        rst     = 1'b1;
        irq_src = 8'h00;
        nmi_src = 1'b0;
        cs      = 1'b0;
        rwb     = 1'b1;
        addr    = 2'd0;
        d_in    = 8'h00;

        // reset state
        repeat (2) tick();
        chk("rst_irqb", {7'd0, irqb}, 8'h01);
        chk("rst_nmib", {7'd0, nmib}, 8'h01);
        rd_chk("rst_status", 2'd0, 8'h00);
        rd_chk("rst_enable", 2'd1, 8'h00);
        rd_chk("rst_mode",   2'd2, 8'h00);
        rd_chk("rst_id",     2'd3, 8'h00);
        rst = 1'b0;
        repeat (2) tick();

        // level mode, source 0: assert and deassert latency
        wr(2'd1, 8'h01);
        wr(2'd2, 8'h00);
        irq_src[0] = 1'b1;
        repeat (3) tick();
        chk("lvl_irqb_e3", {7'd0, irqb}, 8'h01);
        tick();
        chk("lvl_irqb_e4", {7'd0, irqb}, 8'h00);
        rd_chk("lvl_id", 2'd3, 8'h80);
        rd_chk("lvl_status", 2'd0, 8'h01);
        irq_src[0] = 1'b0;
        repeat (3) tick();
        chk("lvl_drop_e3", {7'd0, irqb}, 8'h00);
        tick();
        chk("lvl_drop_e4", {7'd0, irqb}, 8'h01);

        // edge mode: one-cycle pulses on sources 3 and 2
        wr(2'd2, 8'hFF);
        wr(2'd1, 8'h0C);
        irq_src = 8'h0C;
        tick();
        irq_src = 8'h00;
        repeat (3) tick();
        chk("edge_irqb", {7'd0, irqb}, 8'h00);
        rd_chk("edge_status", 2'd0, 8'h0C);
        rd_chk("edge_id", 2'd3, 8'h82);
        cs  = 1'b0;
        rwb = 1'b1;
        #1;
        chk("bus_idle", d_out, 8'h00);

        // ENABLE=0 masks irqb but keeps pending
        wr(2'd1, 8'h00);
        tick();
        chk("mask_irqb", {7'd0, irqb}, 8'h01);
        rd_chk("mask_status", 2'd0, 8'h0C);
        wr(2'd1, 8'h0C);
        tick();
        chk("unmask_irqb", {7'd0, irqb}, 8'h00);

        // W1C one bit at a time
        wr(2'd0, 8'h04);
        rd_chk("w1c_status", 2'd0, 8'h08);
        rd_chk("w1c_id", 2'd3, 8'h83);
        wr(2'd0, 8'h08);
        chk("w1c_irqb_lag", {7'd0, irqb}, 8'h00);
        tick();
        chk("w1c_irqb", {7'd0, irqb}, 8'h01);
        rd_chk("w1c_status0", 2'd0, 8'h00);

        // software trigger via ID (edge mode sets, level mode ignores)
        wr(2'd3, 8'h40);
        rd_chk("sw_status", 2'd0, 8'h40);
        rd_chk("sw_id_masked", 2'd3, 8'h00);
        tick();
        chk("sw_irqb", {7'd0, irqb}, 8'h01);
        wr(2'd0, 8'h40);
        rd_chk("sw_clr", 2'd0, 8'h00);
        wr(2'd2, 8'hFE);
        wr(2'd3, 8'h01);
        rd_chk("sw_level_ign", 2'd0, 8'h00);
        wr(2'd2, 8'hFF);

        // set beats clear: W1C lands on the edge that detects source 5
        irq_src[5] = 1'b1;
        repeat (2) tick();
        wr(2'd0, 8'h20);
        rd_chk("setwin_status", 2'd0, 8'h20);
        wr(2'd0, 8'h20);
        rd_chk("setwin_clr", 2'd0, 8'h00);
        irq_src[5] = 1'b0;
        repeat (3) tick();

        // NMI: single pulse, low on steps 3..6
        nmi_run("nmi_single", 32'hFFFF_FFFF, 32'hFFFF_FF87);
        // second rise during LOW: second pulse after 3 high cycles
        nmi_run("nmi_double", 32'hFFFF_FFF3, 32'hFFFF_C387);
        // three extra rises during one pulse merge into one extra pulse
        nmi_run("nmi_merge",  32'h0000_0055, 32'hFFFF_C387);

        // reset during NMI pulse with IRQ pending
        irq_src = 8'h04;
        nmi_src = 1'b1;
        repeat (5) tick();
        chk("pre_rst_irqb", {7'd0, irqb}, 8'h00);
        chk("pre_rst_nmib", {7'd0, nmib}, 8'h00);
        rst     = 1'b1;
        nmi_src = 1'b0;
        #1;
        chk("async_irqb", {7'd0, irqb}, 8'h01);
        chk("async_nmib", {7'd0, nmib}, 8'h01);
        rd_chk("async_status", 2'd0, 8'h00);
        rd_chk("async_enable", 2'd1, 8'h00);
        tick();
        rst = 1'b0;
        // source 2 still high across release; edge mode set on edge 1
        wr(2'd2, 8'hFF);
        tick();
        rd_chk("rel_status_e2", 2'd0, 8'h00);
        tick();
        rd_chk("rel_status_e3", 2'd0, 8'h04);
        chk("rel_irqb", {7'd0, irqb}, 8'h01);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("rel_nmib[%0d]", i), {7'd0, nmib}, 8'h01);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
